store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_pkg.sv | 39 +++
 rtl/store_align.sv | 55 +++++
 rtl/store_buffer.sv | 166 ++++++++++++++++
 tb/tb_store_buffer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_buffer_pkg.sv
// ---------------------------------------------------------------------------
// store_buffer_pkg
//   Shared types for the store buffer slice.
//   - st_width_e : store width encodings as they arrive on st_f3
//                  (SB = byte, SH = halfword, SW = word).
//   - sb_entry_t : one buffered store as it sits in the queue and as it
//                  is presented to data memory: word address, lane-aligned
//                  write data, and byte lane enables.
//   - st_width_bytes : number of bytes moved by a store width, 0 when the
//                  encoding is not a legal store.
// ---------------------------------------------------------------------------
package store_buffer_pkg;

  typedef enum logic [2:0] {
    ST_SB = 3'b000,
    ST_SH = 3'b001,
    ST_SW = 3'b010
  } st_width_e;

  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } sb_entry_t;

  // Width in bytes of a store encoding; 0 marks an illegal encoding.
  function automatic logic [2:0] st_width_bytes(input logic [2:0] f3);
    logic [2:0] nbytes;
    nbytes = 3'd0;
    case (f3)
      ST_SB:   nbytes = 3'd1;
      ST_SH:   nbytes = 3'd2;
      ST_SW:   nbytes = 3'd4;
      default: nbytes = 3'd0;
    endcase
    return nbytes;
  endfunction

endpackage

// File: rtl/store_align.sv
// ---------------------------------------------------------------------------
// store_align
//   Purely combinational front end of the store buffer. Checks that the
//   offered store has a legal width and a naturally aligned address, and
//   builds the queue entry: word address, source data replicated across
//   all lanes, and the byte enables selecting the lanes actually written.
//
// Ports
//   st_addr  in  32  store byte address
//   st_data  in  32  store source, value held in the low-order bytes
//   st_f3    in   3  store width encoding (see st_width_e)
//   st_ok    out  1  store is legal and aligned, may be enqueued
//   st_entry out     entry to enqueue (only meaningful when st_ok)
// ---------------------------------------------------------------------------
module store_align
  import store_buffer_pkg::*;
(
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_f3,
  output logic        st_ok,
  output sb_entry_t   st_entry
);

  // Decode the width, check natural alignment, and replicate the source
  // value across every lane so the memory only has to honour byte enables.
  // Replication means the data bus never depends on the address offset;
  // only the enables shift with it.
  always_comb begin
    st_ok         = 1'b0;
    st_entry      = '0;
    st_entry.addr = st_addr[31:2];
    case (st_f3)
      ST_SB: begin
        st_ok         = 1'b1;
        st_entry.data = {4{st_data[7:0]}};
        st_entry.be   = 4'b0001 << st_addr[1:0];
      end
      ST_SH: begin
        st_ok         = ~st_addr[0];
        st_entry.data = {2{st_data[15:0]}};
        st_entry.be   = 4'b0011 << st_addr[1:0];
      end
      ST_SW: begin
        st_ok         = (st_addr[1:0] == 2'b00);
        st_entry.data = st_data;
        st_entry.be   = 4'b1111;
      end
      default: begin
        st_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   In-order store buffer between the CPU store path and data memory.
//   Legal, aligned stores are queued (up to DEPTH entries) and drained in
//   FIFO order toward memory, one entry per mem_ready handshake. A load
//   address is compared against every held entry to flag RAW hazards.
//
// Parameters
//   DEPTH             number of entries, power of two in 2..16
//
// Ports
//   clk               in   1  rising-edge clock
//   rst_n             in   1  synchronous, active-low reset
//   st_valid          in   1  CPU offers a store this cycle
//   st_ready          out  1  buffer can take a store (not full)
//   st_addr           in  32  store byte address
//   st_data           in  32  store source data
//   st_f3             in   3  store width encoding
//   st_err            out  1  pulse: previous offered store was rejected
//   ld_addr           in  32  byte address of the load executing now
//   ld_hazard         out  1  a held store targets the load's word
//   mem_write_enable  out  1  head entry valid toward memory
//   mem_address       out 30  head word address
//   mem_write_data    out 32  head lane-aligned data
//   mem_byte_en       out  4  head byte lane enables
//   mem_ready         in   1  memory consumes the head this cycle
//   empty             out  1  no entries held
// ---------------------------------------------------------------------------
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [2:0]  st_f3,
  output logic        st_err,
  input  logic [31:0] ld_addr,
  output logic        ld_hazard,
  output logic        mem_write_enable,
  output logic [29:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic [3:0]  mem_byte_en,
  input  logic        mem_ready,
  output logic        empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  sb_entry_t        entry_q [DEPTH];
  sb_entry_t        entry_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             st_err_q, st_err_d;

  logic             align_ok;
  sb_entry_t        align_entry;
  sb_entry_t        head;
  logic             push;
  logic             pop;
  logic             unused_ld_offset;

  store_align u_align (
    .st_addr  (st_addr),
    .st_data  (st_data),
    .st_f3    (st_f3),
    .st_ok    (align_ok),
    .st_entry (align_entry)
  );

  // Only the word part of the load address matters for the hazard check.
  assign unused_ld_offset = ^ld_addr[1:0];

  // Handshake and status come straight from registered state so st_ready
  // never depends on this cycle's pop; a full buffer refuses a store even
  // while memory is draining the head.
  assign st_ready         = (count_q != FULL_CNT);
  assign empty            = (count_q == '0);
  assign mem_write_enable = ~empty;
  assign st_err           = st_err_q;

  // The memory side sees the registered head entry, forced to zero while
  // nothing is held so stale slot contents never leak onto the bus.
  assign head           = entry_q[rd_ptr_q];
  assign mem_address    = empty ? '0 : head.addr;
  assign mem_write_data = empty ? '0 : head.data;
  assign mem_byte_en    = empty ? '0 : head.be;

  // A load hazards on any held entry with the same word address. The store
  // being offered this cycle is not held yet, so it never contributes; the
  // head being popped this cycle is still valid and still does.
  always_comb begin
    ld_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (entry_q[i].addr == ld_addr[31:2])) begin
        ld_hazard = 1'b1;
      end
    end
  end

  // Next-state for the queue. Push writes the slot at the write pointer,
  // pop retires the slot at the read pointer. They never touch the same
  // slot in one cycle: equal pointers mean empty (no pop) or full (no
  // push). Pointers are exactly log2(DEPTH) bits wide so they wrap by
  // themselves. A rejected store raises st_err for exactly one cycle.
  always_comb begin
    push     = st_valid && st_ready && align_ok;
    pop      = mem_write_enable && mem_ready;
    entry_d  = entry_q;
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    st_err_d = st_valid && st_ready && ~align_ok;

    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PTR_W'(1);
    end

    if (push) begin
      entry_d[wr_ptr_q] = align_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State registers. Reset wins over any push or pop in the same cycle and
  // throws away every held store without presenting it to memory.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
      st_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      st_err_q <= st_err_d;
      for (int i = 0; i < DEPTH; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// ---------------------------------------------------------------------------
// tb_store_buffer
//   Scoreboard bench for store_buffer. A reference model updated on every
//   rising edge tracks the queue occupancy and pushes the expected memory
//   entry for every store it judges acceptable; an independent monitor on
//   the falling edge compares status outputs and the presented head entry
//   against the model and pops the scoreboard on each memory handshake.
//   Directed sequences cover the worked examples, then random traffic.
// ---------------------------------------------------------------------------
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_f3;
  logic        st_err;
  logic [31:0] ld_addr;
  logic        ld_hazard;
  logic        mem_write_enable;
  logic [29:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_en;
  logic        mem_ready;
  logic        empty;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sb_q[$];
  int   model_cnt = 0;
  bit   exp_err   = 1'b0;
  bit   started   = 1'b0;
  int   n_cmp     = 0;
  int   n_bad     = 0;

  always #5 clk = ~clk;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .st_valid         (st_valid),
    .st_ready         (st_ready),
    .st_addr          (st_addr),
    .st_data          (st_data),
    .st_f3            (st_f3),
    .st_err           (st_err),
    .ld_addr          (ld_addr),
    .ld_hazard        (ld_hazard),
    .mem_write_enable (mem_write_enable),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_byte_en      (mem_byte_en),
    .mem_ready        (mem_ready),
    .empty            (empty)
  );

  // Bytes moved by a store width; 0 for encodings that are not stores.
  function automatic int st_size(input logic [2:0] f3);
    case (f3)
      3'b000:  return 1;
      3'b001:  return 2;
      3'b010:  return 4;
      default: return 0;
    endcase
  endfunction

  // A store is legal when its width is known and the address is a
  // multiple of that width.
  function automatic bit st_legal(input logic [31:0] addr, input logic [2:0] f3);
    int sz;
    sz = st_size(f3);
    if (sz == 0) return 1'b0;
    return (addr % sz) == 0;
  endfunction

  // Memory view of a store: lane l carries source byte (l mod size), and
  // the enabled lanes are the size bytes starting at the byte offset.
  function automatic exp_t make_exp(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [2:0] f3);
    exp_t e;
    int   sz;
    int   off;
    sz     = st_size(f3);
    off    = int'(addr[1:0]);
    e.addr = addr[31:2];
    e.data = '0;
    e.be   = '0;
    for (int l = 0; l < 4; l++) begin
      e.data[l*8 +: 8] = data[(l % sz)*8 +: 8];
      e.be[l]          = (l >= off) && (l < off + sz);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs just after a rising edge and hold them
  // through the next rising edge.
  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] d,
                               input logic [2:0] f3, input logic [31:0] la, input logic mr);
    st_valid  = v;
    st_addr   = a;
    st_data   = d;
    st_f3     = f3;
    ld_addr   = la;
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  task automatic idleHalf(input logic mr);
    st_valid  = 1'b0;
    mem_ready = mr;
    @(negedge clk);
  endtask

  task automatic finishCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: on each rising edge decide, from the bench's own
  // occupancy count and the legality rules, whether a store was taken,
  // whether the head left, and whether a rejection pulse is due.
  initial begin
    bit slot;
    bit ok;
    bit do_pop;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        sb_q.delete();
        model_cnt = 0;
        exp_err   = 1'b0;
        started   = 1'b1;
      end else begin
        slot    = st_valid && (model_cnt != DEPTH);
        ok      = st_legal(st_addr, st_f3);
        do_pop  = (model_cnt != 0) && mem_ready;
        exp_err = slot && !ok;
        if (slot && ok) begin
          sb_q.push_back(make_exp(st_addr, st_data, st_f3));
          model_cnt++;
        end
        if (do_pop) model_cnt--;
      end
    end
  end

  // Monitor: mid-cycle comparison of all outputs against the model, then
  // retire the scoreboard head when memory takes it this cycle.
  initial begin
    bit   hz;
    exp_t h;
    forever begin
      @(negedge clk);
      if (started) begin
        checkOutput("st_ready", 32'(st_ready), 32'(model_cnt != DEPTH));
        checkOutput("empty", 32'(empty), 32'(model_cnt == 0));
        checkOutput("st_err", 32'(st_err), 32'(exp_err));
        checkOutput("mem_we", 32'(mem_write_enable), 32'(sb_q.size() != 0));
        hz = 1'b0;
        foreach (sb_q[i]) if (sb_q[i].addr == ld_addr[31:2]) hz = 1'b1;
        checkOutput("ld_hazard", 32'(ld_hazard), 32'(hz));
        if (sb_q.size() != 0) begin
          h = sb_q[0];
          checkOutput("mem_address", 32'(mem_address), 32'(h.addr));
          checkOutput("mem_write_data", mem_write_data, h.data);
          checkOutput("mem_byte_en", 32'(mem_byte_en), 32'(h.be));
          if (mem_ready) void'(sb_q.pop_front());
        end else begin
          checkOutput("mem_address_idle", 32'(mem_address), 32'h0);
          checkOutput("mem_write_data_idle", mem_write_data, 32'h0);
          checkOutput("mem_byte_en_idle", 32'(mem_byte_en), 32'h0);
        end
      end
    end
  end

  // Stimulus: worked examples first, then randomized traffic with the
  // occasional mid-stream reset.
  initial begin
    rst_n     = 1'b0;
    st_valid  = 1'b0;
    st_addr   = '0;
    st_data   = '0;
    st_f3     = '0;
    ld_addr   = '0;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b0);

    // Byte store at offset 3 lands in the top lane.
    applyStimulus(1'b1, 32'h0000_0013, 32'hAABBCC5A, 3'b000, 32'h0, 1'b0);
    idleHalf(1'b0);
    checkOutput("sb_addr", 32'(mem_address), 32'h4);
    checkOutput("sb_be", 32'(mem_byte_en), 32'b1000);
    checkOutput("sb_data", mem_write_data, 32'h5A5A5A5A);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);

    // Halfword store in the upper half.
    applyStimulus(1'b1, 32'h0000_0102, 32'h1234BEEF, 3'b001, 32'h0, 1'b0);
    idleHalf(1'b0);
    checkOutput("sh_addr", 32'(mem_address), 32'h40);
    checkOutput("sh_be", 32'(mem_byte_en), 32'b1100);
    checkOutput("sh_data", mem_write_data, 32'hBEEFBEEF);
    finishCycle();
    applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);

    // Misaligned word store is rejected with a one-cycle error pulse.
    applyStimulus(1'b1, 32'h0000_0006, 32'h11223344, 3'b010, 32'h0, 1'b0);
    idleHalf(1'b0);
    checkOutput("sw_misaligned_err", 32'(st_err), 32'h1);
    checkOutput("sw_misaligned_empty", 32'(empty), 32'h1);
    finishCycle();
    idleHalf(1'b0);
    checkOutput("sw_misaligned_err_clear", 32'(st_err), 32'h0);
    finishCycle();

    // Fill to capacity with memory stalled, hold a fifth store, then drain.
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b1, 32'h200 + 32'(4*i), $urandom, 3'b010, 32'h0, 1'b0);
    idleHalf(1'b0);
    checkOutput("full_st_ready", 32'(st_ready), 32'h0);
    finishCycle();
    repeat (3) applyStimulus(1'b1, 32'h210, 32'h55AA55AA, 3'b010, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'h210, 32'h55AA55AA, 3'b010, 32'h0, 1'b1);
    applyStimulus(1'b1, 32'h210, 32'h55AA55AA, 3'b010, 32'h0, 1'b0);
    repeat (DEPTH + 2) applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);

    // Steady state at two entries with push and pop every cycle.
    for (int i = 0; i < 2; i++)
      applyStimulus(1'b1, 32'h300 + 32'(4*i), $urandom, 3'b010, 32'h0, 1'b0);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b1, 32'h308 + 32'(4*i), $urandom, 3'b010, 32'h0, 1'b1);
    repeat (4) applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);

    // Load hazard on the same word, clear on the next word and after pop.
    applyStimulus(1'b1, 32'h0000_0100, 32'hCAFE0001, 3'b010, 32'h0, 1'b0);
    ld_addr = 32'h0000_0103;
    idleHalf(1'b0);
    checkOutput("hazard_same_word", 32'(ld_hazard), 32'h1);
    finishCycle();
    ld_addr = 32'h0000_0104;
    idleHalf(1'b0);
    checkOutput("hazard_next_word", 32'(ld_hazard), 32'h0);
    finishCycle();
    ld_addr = 32'h0000_0103;
    idleHalf(1'b1);
    checkOutput("hazard_while_popping", 32'(ld_hazard), 32'h1);
    finishCycle();
    idleHalf(1'b0);
    checkOutput("hazard_after_pop", 32'(ld_hazard), 32'h0);
    finishCycle();

    // Reset with three entries held while memory is ready.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h400 + 32'(4*i), $urandom, 3'b010, 32'h0, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1'b1, 32'h40C, 32'h99999999, 3'b010, 32'h0, 1'b1);
    rst_n = 1'b1;
    idleHalf(1'b1);
    checkOutput("reset_empty", 32'(empty), 32'h1);
    checkOutput("reset_mem_we", 32'(mem_write_enable), 32'h0);
    finishCycle();
    repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);

    // Random traffic around a small address window so hazards are common.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] f3;
      f3 = ($urandom_range(0, 3) == 3) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      rst_n = ($urandom_range(0, 99) != 0);
      applyStimulus(1'($urandom_range(0, 9) < 7), 32'h100 + 32'($urandom_range(0, 23)),
                    $urandom, f3, 32'h100 + 32'($urandom_range(0, 23)),
                    1'($urandom_range(0, 1)));
      rst_n = 1'b1;
    end
    repeat (DEPTH + 2) applyStimulus(1'b0, 32'h0, 32'h0, 3'b000, 32'h0, 1'b1);
    idleHalf(1'b0);
    checkOutput("final_empty", 32'(empty), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
